knight_tour_ctrl: RTL and testbench
===================================

// Module: knight_tour_ctrl
// PURPOSE
//   Synthesizable, clocked knight's-tour solver: FSM plus board store plus move stack.
//   Searches depth-first with backtracking, trying one candidate move per cycle.
//   Sequences an internal board array and stack; the board stays readable after completion.
//   Emits next/back step pulses for monitors, and busy/done/found status for the testbench.
// PARAMETERS
//   DIM  5  board edge length, legal range 1..8; board holds DIM*DIM squares
//   CW   $clog2(DIM) or 1 if larger  coordinate width (localparam)
//   LW   $clog2(DIM*DIM+1)  level / square-value width (localparam)
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   one-cycle request; sampled only in IDLE or DONE
//   start_x    in   CW  start row, captured with start
//   start_y    in   CW  start column, captured with start
//   busy       out  1   high from the cycle after start is accepted until DONE
//   done       out  1   high while in DONE (level, not pulse)
//   found      out  1   valid when done; 1 = full tour found
//   bad_start  out  1   valid when done; 1 = start coordinates out of range
//   level      out  LW  current tour length (number of occupied squares)
//   step_next  out  1   one-cycle pulse, a square was placed
//   step_back  out  1   one-cycle pulse, a square was removed
//   rd_x       in   CW  board read row
//   rd_y       in   CW  board read column
//   rd_val     out  LW  combinational read of board[rd_x][rd_y]; 0 = empty
// BEHAVIOUR
//   Reset: state IDLE; board all 0; level=0.
//     busy=done=found=bad_start=step_next=step_back=0. Reset mid-search aborts immediately.
//   States: IDLE, PLACE, PROBE, PUSH, POP, DONE.
//   IDLE/DONE with start=1: capture x,y.
//     - If x or y >= DIM: go to DONE with bad_start=1, found=0, board untouched.
//     - Otherwise: clear board (all squares 0), level=0, dir=0, go to PLACE.
//     - start is ignored in every other state.
//   PLACE: board[x][y]=1, level=1, step_next pulse.
//     If DIM*DIM==1 go to DONE (found=1), else go to PROBE.
//   Move table (dir 0..7, dx,dy), fixed order:
//     (+2,+1) (+1,+2) (-1,+2) (-2,+1) (-2,-1) (-1,-2) (+1,-2) (+2,-1)
//   PROBE: one candidate per cycle; nx=x+dx, ny=y+dy computed signed at CW+1 bits.
//     Legal iff 0<=nx<DIM, 0<=ny<DIM and board[nx][ny]==0.
//     - Legal: go to PUSH.
//     - Illegal and dir<7: dir++, stay in PROBE.
//     - Illegal and dir==7: go to POP.
//   PUSH: stack[level]={dir,x,y}; level++; board[nx][ny]=level (new value).
//     x=nx, y=ny, dir=0, step_next pulse.
//     If new level==DIM*DIM go to DONE with found=1, else go to PROBE.
//   POP: board[x][y]=0; level--; step_back pulse.
//     - If level becomes 0: go to DONE with found=0.
//     - Else {d,x,y}=stack[level]. If d==7 stay in POP (pop again next cycle);
//       else dir=d+1, go to PROBE.
//   Stack: DIM*DIM-1 entries (index 1..DIM*DIM-1), each 3+2*CW bits; never overflows by construction.
//   step_next and step_back are never high in the same cycle. Each is asserted exactly
//     in the PLACE/PUSH or POP cycle, respectively.
//   DONE holds the board and level (level=DIM*DIM when found) until the next accepted start.
//   Latency: start accepted at edge N; busy=1 and PLACE at N+1; first PROBE at N+2.
//   rd_val is valid in any state, including mid-search.
// TESTING
//   T1 DIM=5, start (0,0) -> done, found=1, level=25.
//      Board holds values 1..25 each exactly once; board[0][0]=1; every pair of
//      consecutive values is a knight move apart.
//   T2 DIM=3, start (0,0) -> done, found=0, level=0, board all 0.
//      Check step_next count equals step_back count.
//   T3 DIM=1, start (0,0) -> done two cycles after start, found=1, rd_val(0,0)=1.
//   T4 DIM=5, start (5,2) -> done next cycle, bad_start=1, found=0, busy never set.
//      Board from the previous run is unchanged.
//   T5 DIM=5, start (0,0), pulse start again mid-search -> ignored; final result matches T1.
//   T6 DIM=5, assert rst_n=0 for 1 cycle mid-search -> IDLE, level=0, board all 0, outputs 0.
//      A new start (0,0) then matches T1.

Source files
------------

// File: rtl/knight_tour_ctrl.sv
// rtl/knight_tour_ctrl.sv - depth-first knight's tour search engine with board and move stack
//
// Purpose: searches for a knight's tour on a DIM x DIM board, one candidate
// move per clock, backtracking through an internal move stack. The board
// (square -> visit order, 0 = empty) remains readable at all times.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, start_x/_y   start request and start square (taken in IDLE/DONE only)
//   busy, done          search in progress / search finished (level)
//   found, bad_start    result flags, valid while done
//   level               number of occupied squares
//   step_next/back      one-cycle pulses when a square is placed / removed
//   rd_x, rd_y, rd_val  combinational board read port
module knight_tour_ctrl #(
  parameter int DIM = 5,
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int LW = $clog2(DIM * DIM + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] start_x,
  input  logic [CW-1:0] start_y,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          bad_start,
  output logic [LW-1:0] level,
  output logic          step_next,
  output logic          step_back,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  output logic [LW-1:0] rd_val
);

  localparam int NSQ = DIM * DIM;
  localparam int IW  = (NSQ > 1) ? $clog2(NSQ) : 1;
  localparam int SW  = 3 + 2 * CW;

  typedef enum logic [2:0] {
    S_IDLE, S_PLACE, S_PROBE, S_PUSH, S_POP, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cur_x, cur_y;
  logic [2:0]    dir;
  logic [LW-1:0] lvl;
  logic          found_q, bad_q;
  logic [LW-1:0] board [NSQ];
  logic [SW-1:0] stack [NSQ];  // entry 0 unused; entry L saves the square holding value L

  function automatic logic [IW-1:0] sq_idx(input int r, input int c);
    return IW'(r * DIM + c);
  endfunction

  int            dx, dy, nx, ny;
  logic          nxt_in_range, nxt_legal, start_bad, rd_in_range;
  logic [IW-1:0] nxt_idx;
  logic [LW-1:0] lvl_m1;
  logic [2:0]    pop_dir;
  logic [CW-1:0] pop_x, pop_y;

  always_comb begin
    dx = 0;
    dy = 0;
    case (dir)
      3'd0: begin dx =  2; dy =  1; end
      3'd1: begin dx =  1; dy =  2; end
      3'd2: begin dx = -1; dy =  2; end
      3'd3: begin dx = -2; dy =  1; end
      3'd4: begin dx = -2; dy = -1; end
      3'd5: begin dx = -1; dy = -2; end
      3'd6: begin dx =  1; dy = -2; end
      3'd7: begin dx =  2; dy = -1; end
      default: ;
    endcase
  end

  // Candidate arithmetic is done in int so off-board targets stay unambiguous.
  assign nx           = int'(cur_x) + dx;
  assign ny           = int'(cur_y) + dy;
  assign nxt_in_range = (nx >= 0) && (nx < DIM) && (ny >= 0) && (ny < DIM);
  assign nxt_idx      = nxt_in_range ? sq_idx(nx, ny) : '0;
  assign nxt_legal    = nxt_in_range && (board[nxt_idx] == '0);

  assign start_bad = (int'(start_x) >= DIM) || (int'(start_y) >= DIM);
  assign lvl_m1    = lvl - LW'(1);
  assign {pop_dir, pop_x, pop_y} = stack[IW'(lvl_m1)];

  assign rd_in_range = (int'(rd_x) < DIM) && (int'(rd_y) < DIM);
  assign rd_val      = rd_in_range ? board[sq_idx(int'(rd_x), int'(rd_y))] : '0;

  assign level     = lvl;
  assign found     = found_q;
  assign bad_start = bad_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = start_bad ? S_DONE : S_PLACE;
      S_PLACE:        state_nxt = (NSQ == 1) ? S_DONE : S_PROBE;
      S_PROBE: begin
        if (nxt_legal)         state_nxt = S_PUSH;
        else if (dir == 3'd7)  state_nxt = S_POP;
      end
      S_PUSH:         state_nxt = (int'(lvl) + 1 == NSQ) ? S_DONE : S_PROBE;
      // Restored frames that already tried their last move unwind immediately.
      S_POP: begin
        if (lvl == LW'(1))        state_nxt = S_DONE;
        else if (pop_dir == 3'd7) state_nxt = S_POP;
        else                      state_nxt = S_PROBE;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    step_next = 1'b0;
    step_back = 1'b0;
    case (state)
      S_PLACE: begin busy = 1'b1; step_next = 1'b1; end
      S_PROBE: busy = 1'b1;
      S_PUSH:  begin busy = 1'b1; step_next = 1'b1; end
      S_POP:   begin busy = 1'b1; step_back = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_x   <= '0;
      cur_y   <= '0;
      dir     <= '0;
      lvl     <= '0;
      found_q <= 1'b0;
      bad_q   <= 1'b0;
      for (int i = 0; i < NSQ; i++) board[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            found_q <= 1'b0;
            bad_q   <= start_bad;
            if (!start_bad) begin
              cur_x <= start_x;
              cur_y <= start_y;
              dir   <= '0;
              lvl   <= '0;
              for (int i = 0; i < NSQ; i++) board[i] <= '0;
            end
          end
        end
        S_PLACE: begin
          board[sq_idx(int'(cur_x), int'(cur_y))] <= LW'(1);
          lvl     <= LW'(1);
          found_q <= (NSQ == 1);
        end
        S_PROBE: if (!nxt_legal) dir <= dir + 3'd1;
        S_PUSH: begin
          board[nxt_idx] <= lvl + LW'(1);
          lvl     <= lvl + LW'(1);
          cur_x   <= CW'(nx);
          cur_y   <= CW'(ny);
          dir     <= '0;
          found_q <= (int'(lvl) + 1 == NSQ);
        end
        S_POP: begin
          board[sq_idx(int'(cur_x), int'(cur_y))] <= '0;
          lvl <= lvl_m1;
          if (lvl != LW'(1)) begin
            cur_x <= pop_x;
            cur_y <= pop_y;
            dir   <= pop_dir + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_PUSH) stack[IW'(lvl)] <= {dir, cur_x, cur_y};
  end

endmodule

// File: tb/tb_knight_tour_ctrl.sv
// tb/tb_knight_tour_ctrl.sv - directed bench for knight_tour_ctrl at DIM 5, 3 and 1
module tb_knight_tour_ctrl;

  localparam int LIMIT = 400000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       s5_start, b5, d5, f5, bs5, sn5, sb5;
  logic [2:0] s5_x, s5_y, r5_x, r5_y;
  logic [4:0] l5, v5;

  logic       s3_start, b3, d3, f3, bs3, sn3, sb3;
  logic [1:0] s3_x, s3_y, r3_x, r3_y;
  logic [3:0] l3, v3;

  logic       s1_start, b1, d1, f1, bs1, sn1, sb1;
  logic [0:0] s1_x, s1_y, r1_x, r1_y;
  logic [0:0] l1, v1;

  knight_tour_ctrl #(.DIM(5)) u5 (
    .clk(clk), .rst_n(rst_n), .start(s5_start), .start_x(s5_x), .start_y(s5_y),
    .busy(b5), .done(d5), .found(f5), .bad_start(bs5), .level(l5),
    .step_next(sn5), .step_back(sb5), .rd_x(r5_x), .rd_y(r5_y), .rd_val(v5));

  knight_tour_ctrl #(.DIM(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .start_x(s3_x), .start_y(s3_y),
    .busy(b3), .done(d3), .found(f3), .bad_start(bs3), .level(l3),
    .step_next(sn3), .step_back(sb3), .rd_x(r3_x), .rd_y(r3_y), .rd_val(v3));

  knight_tour_ctrl #(.DIM(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .start_x(s1_x), .start_y(s1_y),
    .busy(b1), .done(d1), .found(f1), .bad_start(bs1), .level(l1),
    .step_next(sn1), .step_back(sb1), .rd_x(r1_x), .rd_y(r1_y), .rd_val(v1));

  typedef struct {
    int dut;
    int x;
    int y;
    int exp_bad;
    int exp_found;
    int chk_lvl;
    int exp_lvl;
    int exp_cyc;
  } vec_t;

  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bd[8][8];
  int   snap[5][5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dim_of(input int d);
    return (d == 5) ? 5 : (d == 3) ? 3 : 1;
  endfunction

  function automatic int get_done(input int d);
    return (d == 5) ? int'(d5) : (d == 3) ? int'(d3) : int'(d1);
  endfunction
  function automatic int get_busy(input int d);
    return (d == 5) ? int'(b5) : (d == 3) ? int'(b3) : int'(b1);
  endfunction
  function automatic int get_found(input int d);
    return (d == 5) ? int'(f5) : (d == 3) ? int'(f3) : int'(f1);
  endfunction
  function automatic int get_bad(input int d);
    return (d == 5) ? int'(bs5) : (d == 3) ? int'(bs3) : int'(bs1);
  endfunction
  function automatic int get_sn(input int d);
    return (d == 5) ? int'(sn5) : (d == 3) ? int'(sn3) : int'(sn1);
  endfunction
  function automatic int get_sb(input int d);
    return (d == 5) ? int'(sb5) : (d == 3) ? int'(sb3) : int'(sb1);
  endfunction
  function automatic int get_level(input int d);
    return (d == 5) ? int'(l5) : (d == 3) ? int'(l3) : int'(l1);
  endfunction

  task automatic drive_start(input int d, input logic s, input int sx, input int sy);
    case (d)
      5: begin s5_start = s; s5_x = sx[2:0]; s5_y = sy[2:0]; end
      3: begin s3_start = s; s3_x = sx[1:0]; s3_y = sy[1:0]; end
      default: begin s1_start = s; s1_x = sx[0:0]; s1_y = sy[0:0]; end
    endcase
  endtask

  task automatic read_board(input int d);
    for (int x = 0; x < dim_of(d); x++) begin
      for (int y = 0; y < dim_of(d); y++) begin
        case (d)
          5: begin r5_x = x[2:0]; r5_y = y[2:0]; #1; bd[x][y] = int'(v5); end
          3: begin r3_x = x[1:0]; r3_y = y[1:0]; #1; bd[x][y] = int'(v3); end
          default: begin r1_x = x[0:0]; r1_y = y[0:0]; #1; bd[x][y] = int'(v1); end
        endcase
      end
    end
  endtask

  function automatic int nonzero_count(input int d);
    int n = 0;
    for (int x = 0; x < dim_of(d); x++)
      for (int y = 0; y < dim_of(d); y++)
        if (bd[x][y] != 0) n++;
    return n;
  endfunction

  // Start request: assert for one clock, then release; returns after the accepting edge.
  task automatic kick(input int d, input int sx, input int sy);
    @(negedge clk);
    drive_start(d, 1'b1, sx, sy);
    @(negedge clk);
    drive_start(d, 1'b0, sx, sy);
  endtask

  // cycles counts clock edges from the accepting edge up to the edge that reaches DONE.
  task automatic wait_done(input int d, output int cycles, output int nn, output int nb,
                           output int both, output int busy_any);
    cycles = 1; nn = 0; nb = 0; both = 0; busy_any = 0;
    while (get_done(d) == 0 && cycles < LIMIT) begin
      nn += get_sn(d);
      nb += get_sb(d);
      if (get_sn(d) != 0 && get_sb(d) != 0) both++;
      if (get_busy(d) != 0) busy_any = 1;
      @(negedge clk);
      cycles++;
    end
    if (get_busy(d) != 0) busy_any = 1;
    chk("done reached", get_done(d), 1);
  endtask

  task automatic run(input int d, input int sx, input int sy, output int cycles, output int nn,
                     output int nb, output int both, output int busy_any);
    kick(d, sx, sy);
    wait_done(d, cycles, nn, nb, both, busy_any);
  endtask

  task automatic check_tour(input string tag);
    int seen[26];
    int px[26];
    int py[26];
    int perm_ok = 1;
    int breaks = 0;
    for (int v = 0; v < 26; v++) begin seen[v] = 0; px[v] = 0; py[v] = 0; end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        if (bd[x][y] >= 1 && bd[x][y] <= 25) begin
          seen[bd[x][y]]++;
          px[bd[x][y]] = x;
          py[bd[x][y]] = y;
        end
    for (int v = 1; v <= 25; v++) if (seen[v] != 1) perm_ok = 0;
    for (int v = 1; v < 25; v++) begin
      int ax = px[v+1] - px[v];
      int ay = py[v+1] - py[v];
      if (ax < 0) ax = -ax;
      if (ay < 0) ay = -ay;
      if (ax * ay != 2) breaks++;
    end
    chk({tag, " values 1..25 once"}, perm_ok, 1);
    chk({tag, " board[0][0]"}, bd[0][0], 1);
    chk({tag, " non-knight steps"}, breaks, 0);
  endtask

  function automatic int snap_diffs();
    int n = 0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        if (bd[x][y] != snap[x][y]) n++;
    return n;
  endfunction

  initial begin
    int cyc, nn, nb, both, bany;

    vecs[0] = '{3, 1, 1, 0, 0, 1, 0, 11};
    vecs[1] = '{3, 2, 1, 0, 0, 1, 0, -1};
    vecs[2] = '{3, 3, 0, 1, 0, 0, 0, 1};
    vecs[3] = '{3, 0, 3, 1, 0, 0, 0, 1};
    vecs[4] = '{1, 0, 0, 0, 1, 1, 1, 2};
    vecs[5] = '{1, 1, 0, 1, 0, 0, 0, 1};
    vecs[6] = '{1, 0, 1, 1, 0, 0, 0, 1};
    vecs[7] = '{5, 2, 7, 1, 0, 0, 0, 1};
    vecs[8] = '{5, 7, 7, 1, 0, 0, 0, 1};

    rst_n = 1'b0;
    drive_start(5, 1'b0, 0, 0);
    drive_start(3, 1'b0, 0, 0);
    drive_start(1, 1'b0, 0, 0);
    r5_x = '0; r5_y = '0; r3_x = '0; r3_y = '0; r1_x = '0; r1_y = '0;
    repeat (3) @(negedge clk);

    chk("reset level", int'(l5), 0);
    chk("reset busy", int'(b5), 0);
    chk("reset done", int'(d5), 0);
    chk("reset found", int'(f5), 0);
    chk("reset bad_start", int'(bs5), 0);
    chk("reset steps", int'({sn5, sb5}), 0);
    read_board(5);
    chk("reset board nonzero", nonzero_count(5), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run(vecs[i].dut, vecs[i].x, vecs[i].y, cyc, nn, nb, both, bany);
      chk($sformatf("vec%0d bad_start", i), get_bad(vecs[i].dut), vecs[i].exp_bad);
      chk($sformatf("vec%0d found", i), get_found(vecs[i].dut), vecs[i].exp_found);
      if (vecs[i].chk_lvl != 0)
        chk($sformatf("vec%0d level", i), get_level(vecs[i].dut), vecs[i].exp_lvl);
      if (vecs[i].exp_cyc >= 0)
        chk($sformatf("vec%0d cycles", i), cyc, vecs[i].exp_cyc);
    end

    // T2: 3x3 has no tour; every placement must be undone.
    run(3, 0, 0, cyc, nn, nb, both, bany);
    chk("t2 found", int'(f3), 0);
    chk("t2 level", int'(l3), 0);
    chk("t2 next==back", nn - nb, 0);
    chk("t2 next and back together", both, 0);
    read_board(3);
    chk("t2 board nonzero", nonzero_count(3), 0);

    // T3: single square board.
    run(1, 0, 0, cyc, nn, nb, both, bany);
    chk("t3 cycles to done", cyc, 2);
    chk("t3 found", int'(f1), 1);
    chk("t3 level", int'(l1), 1);
    read_board(1);
    chk("t3 rd_val(0,0)", bd[0][0], 1);

    // T1: full 5x5 tour from the corner.
    run(5, 0, 0, cyc, nn, nb, both, bany);
    chk("t1 found", int'(f5), 1);
    chk("t1 level", int'(l5), 25);
    chk("t1 bad_start", int'(bs5), 0);
    chk("t1 net placements", nn - nb, 25);
    chk("t1 next and back together", both, 0);
    read_board(5);
    check_tour("t1");
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        snap[x][y] = bd[x][y];

    // T4: out-of-range start leaves the finished board alone.
    run(5, 5, 2, cyc, nn, nb, both, bany);
    chk("t4 cycles to done", cyc, 1);
    chk("t4 busy seen", bany, 0);
    chk("t4 bad_start", int'(bs5), 1);
    chk("t4 found", int'(f5), 0);
    read_board(5);
    chk("t4 board changes", snap_diffs(), 0);

    // T5: a second start while searching is ignored.
    kick(5, 0, 0);
    repeat (20) @(negedge clk);
    chk("t5 busy before pulse", int'(b5), 1);
    drive_start(5, 1'b1, 3, 3);
    @(negedge clk);
    drive_start(5, 1'b0, 3, 3);
    chk("t5 busy after pulse", int'(b5), 1);
    wait_done(5, cyc, nn, nb, both, bany);
    chk("t5 found", int'(f5), 1);
    chk("t5 level", int'(l5), 25);
    chk("t5 bad_start", int'(bs5), 0);
    read_board(5);
    check_tour("t5");
    chk("t5 differs from t1", snap_diffs(), 0);

    // T6: reset in the middle of a search.
    kick(5, 0, 0);
    repeat (30) @(negedge clk);
    chk("t6 busy before reset", int'(b5), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6 level", int'(l5), 0);
    chk("t6 status outputs", int'({b5, d5, f5, bs5, sn5, sb5}), 0);
    rst_n = 1'b1;
    read_board(5);
    chk("t6 board nonzero", nonzero_count(5), 0);
    run(5, 0, 0, cyc, nn, nb, both, bany);
    chk("t6 found", int'(f5), 1);
    chk("t6 level after rerun", int'(l5), 25);
    read_board(5);
    check_tour("t6");
    chk("t6 differs from t1", snap_diffs(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
